// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_AW   = $clog2(NUM_REGS);
    localparam int unsigned WB_N_REQ = 3;

    typedef enum logic [0:0] {
        WB_IDLE  = 1'b0,
        WB_CLEAR = 1'b1
    } wb_state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after last_grant, wrapping to 0.
module rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned N  = WB_N_REQ,
    parameter int unsigned GW = id_width(N)
)(
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last_grant,
    output logic [N-1:0]  grant
);

    always_comb begin
        int unsigned idx;
        logic        found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = 32'(last_grant) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && (i == idx) && req[i]) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter with optional zero-fill sequence.
// Define COTM32_WB_CLEAR_EN to build in the WB_CLEAR state and its counter.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ  = WB_N_REQ,
    parameter int unsigned N_REGS = NUM_REGS,
    localparam int unsigned AW    = $clog2(N_REGS),
    localparam int unsigned GW    = id_width(N_REQ)
)(
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [N_REQ-1:0]              i_req_valid,
    input  logic [N_REQ-1:0][AW-1:0]      i_req_addr,
    input  logic [N_REQ-1:0][XLEN-1:0]    i_req_data,
    output logic [N_REQ-1:0]              o_req_ready,
    input  logic                          i_trap_req,
    input  logic                          i_clear_req,
    output logic                          o_clear_busy,
    output logic                          o_rf_we,
    output logic [AW-1:0]                 o_rf_waddr,
    output logic [XLEN-1:0]               o_rf_wdata,
    output logic [GW-1:0]                 o_grant_id
);

    wb_state_e        state;
    logic [GW-1:0]    last_grant;
    logic [N_REQ-1:0] grant;
    logic [GW-1:0]    hs_id;
    logic             hs;

    rr_arbiter #(
        .N  (N_REQ),
        .GW (GW)
    ) u_rr_arbiter (
        .req        (i_req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Acceptance is offered only in WB_IDLE and never while a trap is in progress.
    always_comb begin
        o_req_ready = '0;
        if ((state == WB_IDLE) && !i_trap_req) begin
            o_req_ready = grant;
        end
    end

    assign hs = |(i_req_valid & o_req_ready);

    always_comb begin
        hs_id = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant[i]) begin
                hs_id = GW'(i);
            end
        end
    end

`ifdef COTM32_WB_CLEAR_EN
    logic [AW-1:0] counter;

    assign o_clear_busy = (state == WB_CLEAR);
`else
    logic unused_clear_req;

    assign state            = WB_IDLE;
    assign unused_clear_req = i_clear_req;
    assign o_clear_busy     = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_grant <= GW'(N_REQ - 1);
            o_rf_we    <= 1'b0;
            o_rf_waddr <= '0;
            o_rf_wdata <= '0;
            o_grant_id <= '0;
`ifdef COTM32_WB_CLEAR_EN
            state      <= WB_IDLE;
            counter    <= AW'(1);
`endif
        end else begin
            o_rf_we <= 1'b0;
            // A write to x0 still completes its handshake but never reaches the file.
            if (hs) begin
                last_grant <= hs_id;
                o_rf_we    <= (i_req_addr[hs_id] != '0);
                o_rf_waddr <= i_req_addr[hs_id];
                o_rf_wdata <= i_req_data[hs_id];
                o_grant_id <= hs_id;
            end
`ifdef COTM32_WB_CLEAR_EN
            case (state)
                WB_IDLE: begin
                    if (i_clear_req && !i_trap_req) begin
                        state   <= WB_CLEAR;
                        counter <= AW'(1);
                    end
                end
                WB_CLEAR: begin
                    // A trap pauses the fill; the counter holds its place.
                    if (!i_trap_req) begin
                        o_rf_we    <= 1'b1;
                        o_rf_waddr <= counter;
                        o_rf_wdata <= '0;
                        if (counter == AW'(N_REGS - 1)) begin
                            state   <= WB_IDLE;
                            counter <= AW'(1);
                        end else begin
                            counter <= counter + AW'(1);
                        end
                    end
                end
                default: state <= WB_IDLE;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table plus clear/reset sequences.
module tb_regfile_wb_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        req_valid;
    logic [2:0][4:0]   req_addr;
    logic [2:0][31:0]  req_data;
    logic [2:0]        req_ready;
    logic              trap_req;
    logic              clear_req;
    logic              clear_busy;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;
    logic [1:0]        grant_id;

    regfile_wb_arbiter dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .i_req_addr   (req_addr),
        .i_req_data   (req_data),
        .o_req_ready  (req_ready),
        .i_trap_req   (trap_req),
        .i_clear_req  (clear_req),
        .o_clear_busy (clear_busy),
        .o_rf_we      (rf_we),
        .o_rf_waddr   (rf_waddr),
        .o_rf_wdata   (rf_wdata),
        .o_grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       v;
        logic [2:0][4:0]  a;
        logic [2:0][31:0] d;
        logic             trap;
        logic [2:0]       er;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  id;
        logic        chk_id;
    } wr_t;

    wr_t  sb[$];
    vec_t vecs[17];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic pop_check();
        wr_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rf_we", 32'(rf_we), 32'(e.we));
            if (e.we) begin
                chk("rf_waddr", 32'(rf_waddr), 32'(e.addr));
                chk("rf_wdata", rf_wdata, e.data);
                if (e.chk_id) chk("grant_id", 32'(grant_id), 32'(e.id));
            end
        end
    endtask

    function automatic vec_t mk(input logic [2:0] v, input logic [2:0][4:0] a,
                                input logic [2:0][31:0] d, input logic trap, input logic [2:0] er);
        vec_t t;
        t.v = v; t.a = a; t.d = d; t.trap = trap; t.er = er;
        return t;
    endfunction

    // One cycle: check last cycle's write, drive, check ready/busy, queue the expected write.
    task automatic step(input logic [2:0] v, input logic [2:0][4:0] a, input logic [2:0][31:0] d,
                        input logic trap, input logic clr, input logic [2:0] er, input logic eb,
                        input logic ov, input wr_t ow);
        wr_t w;
        @(negedge clk);
        pop_check();
        req_valid = v; req_addr = a; req_data = d; trap_req = trap; clear_req = clr;
        #1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("clear_busy", 32'(clear_busy), 32'(eb));
        w = '{1'b0, 5'd0, 32'd0, 2'd0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            if (er[i]) begin
                w.we = (a[i] != 5'd0); w.addr = a[i]; w.data = d[i];
                w.id = 2'(i); w.chk_id = 1'b1;
            end
        end
        sb.push_back(ov ? ow : w);
    endtask

    function automatic wr_t clrw(input int k);
        return '{1'b1, 5'(k), 32'd0, 2'd0, 1'b0};
    endfunction

    initial begin
        logic [2:0][4:0]  a0, a9, av;
        logic [2:0][31:0] d0, d9, dv;
        wr_t nowr;
        nowr = '{1'b0, 5'd0, 32'd0, 2'd0, 1'b0};
        a0 = '0; d0 = '0;
        a9 = {5'd0, 5'd0, 5'd9};   d9 = {32'h0, 32'h0, 32'h99};
        av = {5'd12, 5'd11, 5'd10}; dv = {32'hC2, 32'hC1, 32'hC0};

        vecs[0]  = mk(3'b011, {5'd0, 5'd6, 5'd5}, {32'h0, 32'h22, 32'h11}, 1'b0, 3'b001);
        vecs[1]  = mk(3'b010, {5'd0, 5'd6, 5'd5}, {32'h0, 32'h22, 32'h11}, 1'b0, 3'b010);
        vecs[2]  = mk(3'b100, {5'd7, 5'd6, 5'd5}, {32'h33, 32'h22, 32'h11}, 1'b0, 3'b100);
        vecs[3]  = mk(3'b111, av, dv, 1'b0, 3'b001);
        vecs[4]  = mk(3'b111, av, dv, 1'b0, 3'b010);
        vecs[5]  = mk(3'b111, av, dv, 1'b0, 3'b100);
        vecs[6]  = mk(3'b111, av, dv, 1'b0, 3'b001);
        vecs[7]  = mk(3'b111, av, dv, 1'b0, 3'b010);
        vecs[8]  = mk(3'b111, av, dv, 1'b0, 3'b100);
        vecs[9]  = mk(3'b100, {5'd0, 5'd11, 5'd10}, {32'hDEAD, 32'hC1, 32'hC0}, 1'b0, 3'b100);
        vecs[10] = mk(3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'h44}, 1'b1, 3'b000);
        vecs[11] = mk(3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'h44}, 1'b1, 3'b000);
        vecs[12] = mk(3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'h44}, 1'b0, 3'b001);
        vecs[13] = mk(3'b000, av, dv, 1'b0, 3'b000);
        vecs[14] = mk(3'b101, av, dv, 1'b0, 3'b100);
        vecs[15] = mk(3'b101, av, dv, 1'b0, 3'b001);
        vecs[16] = mk(3'b000, av, dv, 1'b0, 3'b000);

        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; trap_req = 1'b0; clear_req = 1'b0;
        #12;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_clear_busy", 32'(clear_busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].trap, 1'b0, vecs[i].er, 1'b0, 1'b0, nowr);
        end

`ifdef COTM32_WB_CLEAR_EN
        // Same-cycle handshake completes first, then 31 zero writes with a 2-cycle trap pause.
        step(3'b001, a9, d9, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, nowr);
        for (int k = 1; k <= 31; k++) begin
            if (k == 12) begin
                repeat (2) step(3'b111, av, dv, 1'b1, 1'b0, 3'b000, 1'b1, 1'b1, nowr);
            end
            step(3'b111, av, dv, 1'b0, (k == 20), 3'b000, 1'b1, 1'b1, clrw(k));
        end
        step(3'b000, a0, d0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, nowr);
        step(3'b000, a0, d0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, nowr);

        // Reset while the counter sits at 10 aborts the fill.
        step(3'b000, a0, d0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, nowr);
        for (int k = 1; k <= 9; k++) begin
            step(3'b000, a0, d0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, clrw(k));
        end
        @(negedge clk);
        pop_check();
        chk("busy_before_rst", 32'(clear_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("midclr_rst_busy", 32'(clear_busy), 32'd0);
        chk("midclr_rst_we", 32'(rf_we), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) step(3'b000, a0, d0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, nowr);
`else
        // Clear pulses are ignored; the concurrent handshake proceeds normally.
        step(3'b001, a9, d9, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, nowr);
        step(3'b000, a0, d0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, nowr);
        repeat (3) step(3'b000, a0, d0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, nowr);
`endif

        @(negedge clk);
        pop_check();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
